// File: rtl/dp_mem_responder_if.sv
// Datapath-to-memory signal bundle for dp_mem_responder.
// The slave modport is the responder's view; master is the datapath/RAM environment.
interface dp_mem_responder_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        halt;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;
    logic        busy;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt, ramload, ramready,
        output ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore, busy
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt, ramload, ramready,
        input  ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore, busy
    );
endinterface

// File: rtl/dp_mem_responder.sv
// Arbitrates datapath instruction/data requests onto a single RAM port.
// Data requests win; each access waits LAT cycles, then for ramready, before completing.
module dp_mem_responder #(
    parameter int unsigned LAT = 2
) (
    input logic               CLK,
    input logic               RST,
    dp_mem_responder_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StDacc, StIacc} state_e;

    localparam logic [3:0] CntInit = 4'(LAT - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] store_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] iload_q;
    logic [31:0] dload_q;

    logic d_req;
    logic req_held;
    logic done;
    logic access;
    logic dhit;
    logic ihit;

    always_comb begin
        d_req    = bus.dmemREN | bus.dmemWEN;
        access   = (state_q != StIdle);
        // The serviced request must still be present, otherwise the access aborts.
        req_held = ((state_q == StDacc) && d_req) || ((state_q == StIacc) && bus.imemREN);
        done     = req_held && (cnt_q == 4'd0) && bus.ramready;
        dhit     = done && (state_q == StDacc);
        ihit     = done && (state_q == StIacc);
    end

    assign bus.dhit     = dhit;
    assign bus.ihit     = ihit;
    assign bus.dmemload = (dhit && rd_q) ? bus.ramload : dload_q;
    assign bus.imemload = ihit ? bus.ramload : iload_q;
    assign bus.busy     = access;
    assign bus.ramREN   = access & rd_q;
    assign bus.ramWEN   = access & wr_q;
    assign bus.ramaddr  = access ? addr_q : 32'd0;
    assign bus.ramstore = access ? store_q : 32'd0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            store_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            iload_q <= 32'd0;
            dload_q <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!bus.halt && d_req) begin
                        state_q <= StDacc;
                        addr_q  <= bus.dmemaddr;
                        store_q <= bus.dmemstore;
                        rd_q    <= bus.dmemREN;
                        wr_q    <= bus.dmemWEN;
                        cnt_q   <= CntInit;
                    end else if (!bus.halt && bus.imemREN) begin
                        state_q <= StIacc;
                        addr_q  <= bus.imemaddr;
                        store_q <= 32'd0;
                        rd_q    <= 1'b1;
                        wr_q    <= 1'b0;
                        cnt_q   <= CntInit;
                    end
                end
                default: begin
                    if (!req_held) begin
                        state_q <= StIdle;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (bus.ramready) begin
                        state_q <= StIdle;
                        if (state_q == StIacc) begin
                            iload_q <= bus.ramload;
                        end else if (rd_q) begin
                            dload_q <= bus.ramload;
                        end
                    end
                end
            endcase
        end
    end

endmodule
